// File: rtl/cnt_mod_down_ld.sv
// Loadable modulo-N down counter/timer with free-run or one-shot mode.
// Borrow output allows cascading digits; Done pulses once on one-shot completion.
module cnt_mod_down_ld #(
    parameter int unsigned BUS_SIZE = 4,
    parameter int unsigned MODULO   = 10,
    parameter int unsigned CLK_POL  = 1
) (
    input  logic                Clk,
    input  logic                nRst,
    input  logic                En,
    input  logic                Load,
    input  logic [BUS_SIZE-1:0] D,
    input  logic                Start,
    input  logic                Stop,
    input  logic                Wrap,
    output logic [BUS_SIZE-1:0] Q,
    output logic                Bo,
    output logic                Busy,
    output logic                Done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [BUS_SIZE-1:0] QMax = BUS_SIZE'(MODULO - 1);

    state_e              r_state, w_state_nxt;
    logic [BUS_SIZE-1:0] r_q, w_q_nxt;
    logic                w_clk;
    logic                w_q_zero;

    // Falling-edge operation is obtained by inverting the clock into a single register bank.
    assign w_clk    = (CLK_POL != 0) ? Clk : ~Clk;
    assign w_q_zero = (r_q == '0);

    always_ff @(posedge w_clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= StIdle;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        if (Load) begin
            w_q_nxt = (D > QMax) ? QMax : D;
            if (r_state == StDone) begin
                w_state_nxt = StIdle;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (Start) begin
                        w_state_nxt = StRun;
                    end
                end
                StRun: begin
                    if (Stop) begin
                        w_state_nxt = StIdle;
                    end else if (En) begin
                        if (!w_q_zero) begin
                            w_q_nxt = r_q - BUS_SIZE'(1);
                        end else if (Wrap) begin
                            w_q_nxt = QMax;
                        end else begin
                            w_state_nxt = StDone;
                        end
                    end
                end
                StDone: begin
                    w_state_nxt = StIdle;
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase
        end
    end

    assign Q    = r_q;
    assign Busy = (r_state == StRun);
    assign Done = (r_state == StDone);
    // Same-cycle borrow so the next digit steps on the same edge as this one wraps.
    assign Bo   = Busy & En & w_q_zero & ~Load & ~Stop;

endmodule

// File: tb/tb_cnt_mod_down_ld.sv
// Bench for cnt_mod_down_ld: scoreboarded random/directed runs against a behavioural model,
// plus async reset, falling-edge instance and two-digit cascade scenarios.
module tb_cnt_mod_down_ld;

    typedef struct packed {
        logic [3:0] q;
        logic       busy;
        logic       done;
        logic       bo;
    } obs_t;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0, wrap = 1'b0;
    logic [3:0] d = 4'd0;
    logic [3:0] q;
    logic       bo, busy, done;

    logic       n_en = 1'b0, n_load = 1'b0, n_start = 1'b0;
    logic [3:0] n_d = 4'd0;
    logic [3:0] n_q;
    logic       n_bo, n_busy, n_done;

    logic       c_en = 1'b0, c_load = 1'b0, c_start = 1'b0;
    logic [3:0] u_q, t_q;
    logic       u_bo, u_busy, u_done, t_bo, t_busy, t_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];

    // Reference model state: mode 0 idle, 1 counting, 2 finished
    int m_q    = 0;
    int m_mode = 0;

    always #5 clk = ~clk;

    cnt_mod_down_ld #(.BUS_SIZE(4), .MODULO(10), .CLK_POL(1)) u_dut (
        .Clk(clk), .nRst(nrst), .En(en), .Load(load), .D(d), .Start(start), .Stop(stop),
        .Wrap(wrap), .Q(q), .Bo(bo), .Busy(busy), .Done(done)
    );

    cnt_mod_down_ld #(.BUS_SIZE(4), .MODULO(10), .CLK_POL(0)) u_neg (
        .Clk(clk), .nRst(nrst), .En(n_en), .Load(n_load), .D(n_d), .Start(n_start),
        .Stop(1'b0), .Wrap(1'b1), .Q(n_q), .Bo(n_bo), .Busy(n_busy), .Done(n_done)
    );

    cnt_mod_down_ld #(.BUS_SIZE(4), .MODULO(10), .CLK_POL(1)) u_units (
        .Clk(clk), .nRst(nrst), .En(c_en), .Load(c_load), .D(4'd0), .Start(c_start),
        .Stop(1'b0), .Wrap(1'b1), .Q(u_q), .Bo(u_bo), .Busy(u_busy), .Done(u_done)
    );

    cnt_mod_down_ld #(.BUS_SIZE(4), .MODULO(10), .CLK_POL(1)) u_tens (
        .Clk(clk), .nRst(nrst), .En(u_bo), .Load(c_load), .D(4'd2), .Start(c_start),
        .Stop(1'b0), .Wrap(1'b1), .Q(t_q), .Bo(t_bo), .Busy(t_busy), .Done(t_done)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input logic i_en, input logic i_load, input logic [3:0] i_d,
                        input logic i_start, input logic i_stop, input logic i_wrap);
        obs_t e;
        @(posedge clk);
        #2;
        en = i_en; load = i_load; d = i_d; start = i_start; stop = i_stop; wrap = i_wrap;
        e.q    = 4'(m_q);
        e.busy = (m_mode == 1);
        e.done = (m_mode == 2);
        e.bo   = (m_mode == 1) && i_en && (m_q == 0) && !i_load && !i_stop;
        exp_q.push_back(e);
        if (i_load) begin
            m_q = (int'(i_d) > 9) ? 9 : int'(i_d);
            if (m_mode == 2) m_mode = 0;
        end else if (m_mode == 0) begin
            if (i_start) m_mode = 1;
        end else if (m_mode == 1) begin
            if (i_stop) m_mode = 0;
            else if (i_en) begin
                if (m_q > 0) m_q = m_q - 1;
                else if (i_wrap) m_q = 9;
                else m_mode = 2;
            end
        end else begin
            m_mode = 0;
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle against the queue head.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            check("q", int'(q), int'(e.q));
            check("busy", int'(busy), int'(e.busy));
            check("done", int'(done), int'(e.done));
            check("bo", int'(bo), int'(e.bo));
        end
    end

    initial begin
        int v;
        #12 nrst = 1'b1;

        check("reset_q", int'(q), 0);
        check("reset_busy", int'(busy), 0);

        // Free-run from 3 through the wrap
        step(0, 1, 4'd3, 0, 0, 1);
        step(0, 0, 4'd0, 1, 0, 1);
        repeat (7) step(1, 0, 4'd0, 0, 0, 1);

        // One-shot from 2 to completion
        step(0, 1, 4'd2, 0, 0, 0);
        step(0, 0, 4'd0, 1, 0, 0);
        repeat (6) step(1, 0, 4'd0, 0, 0, 0);

        // Load beats Stop, then Stop freezes Q
        step(0, 1, 4'd4, 0, 0, 1);
        step(0, 0, 4'd0, 1, 0, 1);
        step(1, 1, 4'd7, 0, 1, 1);
        step(1, 0, 4'd0, 0, 1, 1);
        repeat (5) step(1, 0, 4'd0, 0, 0, 1);

        // Load in finished state returns to idle
        step(0, 1, 4'd0, 0, 0, 0);
        step(0, 0, 4'd0, 1, 0, 0);
        step(1, 0, 4'd0, 0, 0, 0);
        step(1, 1, 4'd12, 0, 0, 0);
        step(0, 0, 4'd0, 0, 0, 0);

        // Randomized traffic with occasional loads, starts and stops
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 4'($urandom()),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        // Asynchronous reset mid-count with Q=5
        step(0, 1, 4'd5, 0, 0, 1);
        step(0, 0, 4'd0, 1, 0, 1);
        step(0, 0, 4'd0, 0, 0, 1);
        @(posedge clk);
        #2;
        check("pre_reset_q", int'(q), 5);
        check("pre_reset_busy", int'(busy), 1);
        nrst = 1'b0;
        #1;
        check("async_rst_q", int'(q), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        m_q = 0;
        m_mode = 0;
        #1 nrst = 1'b1;
        step(1, 0, 4'd0, 0, 0, 1);
        step(1, 0, 4'd0, 0, 0, 1);

        // Falling-edge instance: clamp and edge sensitivity
        @(posedge clk);
        #2;
        n_d = 4'd15;
        n_load = 1'b1;
        #1 check("neg_before_edge", int'(n_q), 0);
        @(negedge clk);
        #1 check("neg_clamp", int'(n_q), 9);
        n_load = 1'b0;
        n_start = 1'b1;
        n_en = 1'b1;
        @(posedge clk);
        #1 check("neg_busy_hold", int'(n_busy), 0);
        @(negedge clk);
        #1 check("neg_busy", int'(n_busy), 1);
        n_start = 1'b0;
        @(posedge clk);
        #1 check("neg_q_posedge", int'(n_q), 9);
        @(negedge clk);
        #1 check("neg_q_negedge", int'(n_q), 8);

        // Two-digit cascade from 20
        @(posedge clk);
        #2 c_load = 1'b1;
        @(posedge clk);
        #2 c_load = 1'b0;
        c_start = 1'b1;
        check("casc_load", int'(t_q) * 10 + int'(u_q), 20);
        @(posedge clk);
        #2 c_start = 1'b0;
        c_en = 1'b1;
        v = 20;
        check("casc_start", int'(t_q) * 10 + int'(u_q), v);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #2;
            v = (v == 0) ? 99 : v - 1;
            check("casc_value", int'(t_q) * 10 + int'(u_q), v);
        end

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
